// File: rtl/jtcop_obj_pkg.sv
// Shared definitions for the object table scanner: FSM states,
// word offsets inside a table entry and field bit positions.
package jtcop_obj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_CHK,
        ST_RD1,
        ST_RD2,
        ST_ISSUE,
        ST_WAIT
    } obj_state_e;

    localparam logic [1:0] WORD_ATTR = 2'd0;
    localparam logic [1:0] WORD_CODE = 2'd1;
    localparam logic [1:0] WORD_POS  = 2'd2;

    localparam int EN_BIT    = 15;
    localparam int VFLIP_BIT = 14;
    localparam int HFLIP_BIT = 13;
    localparam int SIZE_HI   = 12;
    localparam int SIZE_LO   = 11;
    localparam int Y_HI      = 8;
    localparam int Y_LO      = 0;
    localparam int CODE_HI   = 11;
    localparam int CODE_LO   = 0;
    localparam int PAL_HI    = 15;
    localparam int PAL_LO    = 12;
    localparam int X_HI      = 8;
    localparam int X_LO      = 0;

    function automatic logic [9:0] obj_addr(
        input logic [7:0] entry,
        input logic [1:0] word
    );
        return {entry, word};
    endfunction

endpackage

// File: rtl/jtcop_obj_scan.sv
// Object table scanner: finds sprites crossing vrender and issues draw requests.
// Define JTCOP_OBJ_MULTI_EN to honour the multi-tile height code.
module jtcop_obj_scan
    import jtcop_obj_pkg::*;
#(
    parameter logic [8:0] HOFFSET = 9'd0,
    parameter logic [7:0] LAST    = 8'd255
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        pxl_cen,
    input  logic        hs,
    input  logic [8:0]  vrender,
    output logic [9:0]  tab_addr,
    input  logic [15:0] tab_data,
    output logic        dr_start,
    input  logic        dr_busy,
    output logic [11:0] dr_code,
    output logic [8:0]  dr_xpos,
    output logic [3:0]  dr_ysub,
    output logic        dr_hflip,
    output logic        dr_vflip,
    output logic [3:0]  dr_pal
);

    obj_state_e  state_q, state_d;
    logic [7:0]  entry_q, entry_d;
    logic        hs_l_q, hs_l_d;
    logic [9:0]  tab_addr_q, tab_addr_d;

    // staged request, copied to the dr_* outputs only when issued
    logic [2:0]  t_q, t_d;
    logic [3:0]  ysub_q, ysub_d;
    logic        hflip_q, hflip_d;
    logic        vflip_q, vflip_d;
    logic [11:0] code_q, code_d;
    logic [8:0]  xpos_q, xpos_d;
    logic [3:0]  pal_q, pal_d;

    logic        dr_start_q, dr_start_d;
    logic [11:0] dr_code_q, dr_code_d;
    logic [8:0]  dr_xpos_q, dr_xpos_d;
    logic [3:0]  dr_ysub_q, dr_ysub_d;
    logic        dr_hflip_q, dr_hflip_d;
    logic        dr_vflip_q, dr_vflip_d;
    logic [3:0]  dr_pal_q, dr_pal_d;

    logic        unused_ok;
    logic [1:0]  size;
    logic [8:0]  ydiff;
    logic [8:0]  lim;
    logic        visible;
    logic [2:0]  tmax;
    logic [2:0]  t_calc;
    logic [3:0]  ysub_calc;
    logic        hs_rise;
    logic        at_last;
    logic [7:0]  next_entry;

    assign unused_ok = pxl_cen;

`ifdef JTCOP_OBJ_MULTI_EN
    assign size = tab_data[SIZE_HI:SIZE_LO];
`else
    assign size = 2'd0;
`endif

    assign ydiff     = vrender - tab_data[Y_HI:Y_LO];
    assign lim       = 9'd16 << size;
    assign visible   = tab_data[EN_BIT] && (ydiff < lim);
    assign tmax      = 3'((4'd1 << size) - 4'd1);
    assign t_calc    = tab_data[VFLIP_BIT] ? tmax - ydiff[6:4]
                                           : ydiff[6:4];
    assign ysub_calc = tab_data[VFLIP_BIT] ? ~ydiff[3:0]
                                           : ydiff[3:0];
    assign hs_rise    = hs & ~hs_l_q;
    assign at_last    = entry_q == LAST;
    assign next_entry = entry_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        hs_l_d     = hs;
        tab_addr_d = tab_addr_q;
        t_d        = t_q;
        ysub_d     = ysub_q;
        hflip_d    = hflip_q;
        vflip_d    = vflip_q;
        code_d     = code_q;
        xpos_d     = xpos_q;
        pal_d      = pal_q;
        dr_start_d = 1'b0;
        dr_code_d  = dr_code_q;
        dr_xpos_d  = dr_xpos_q;
        dr_ysub_d  = dr_ysub_q;
        dr_hflip_d = dr_hflip_q;
        dr_vflip_d = dr_vflip_q;
        dr_pal_d   = dr_pal_q;

        unique case (state_q)
            ST_IDLE: ;
            ST_RD0: begin
                tab_addr_d = obj_addr(entry_q, WORD_CODE);
                state_d    = ST_CHK;
            end
            ST_CHK: begin
                if (visible) begin
                    t_d        = t_calc;
                    ysub_d     = ysub_calc;
                    hflip_d    = tab_data[HFLIP_BIT];
                    vflip_d    = tab_data[VFLIP_BIT];
                    tab_addr_d = obj_addr(entry_q, WORD_POS);
                    state_d    = ST_RD1;
                end else if (at_last) begin
                    state_d = ST_IDLE;
                end else begin
                    entry_d    = next_entry;
                    tab_addr_d = obj_addr(next_entry, WORD_ATTR);
                    state_d    = ST_RD0;
                end
            end
            ST_RD1: begin
                code_d  = tab_data[CODE_HI:CODE_LO] + {9'd0, t_q};
                state_d = ST_RD2;
            end
            ST_RD2: begin
                xpos_d  = tab_data[X_HI:X_LO] + HOFFSET;
                pal_d   = tab_data[PAL_HI:PAL_LO];
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!dr_busy) begin
                    dr_start_d = 1'b1;
                    dr_code_d  = code_q;
                    dr_xpos_d  = xpos_q;
                    dr_ysub_d  = ysub_q;
                    dr_hflip_d = hflip_q;
                    dr_vflip_d = vflip_q;
                    dr_pal_d   = pal_q;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // busy only rises the clk after the pulse, so skip that clk
                if (!dr_busy && !dr_start_q) begin
                    if (at_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        entry_d    = next_entry;
                        tab_addr_d = obj_addr(next_entry, WORD_ATTR);
                        state_d    = ST_RD0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (hs_rise) begin
            entry_d    = 8'd0;
            tab_addr_d = obj_addr(8'd0, WORD_ATTR);
            state_d    = ST_RD0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            entry_q    <= 8'd0;
            hs_l_q     <= 1'b1;
            tab_addr_q <= 10'd0;
            t_q        <= 3'd0;
            ysub_q     <= 4'd0;
            hflip_q    <= 1'b0;
            vflip_q    <= 1'b0;
            code_q     <= 12'd0;
            xpos_q     <= 9'd0;
            pal_q      <= 4'd0;
            dr_start_q <= 1'b0;
            dr_code_q  <= 12'd0;
            dr_xpos_q  <= 9'd0;
            dr_ysub_q  <= 4'd0;
            dr_hflip_q <= 1'b0;
            dr_vflip_q <= 1'b0;
            dr_pal_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            hs_l_q     <= hs_l_d;
            tab_addr_q <= tab_addr_d;
            t_q        <= t_d;
            ysub_q     <= ysub_d;
            hflip_q    <= hflip_d;
            vflip_q    <= vflip_d;
            code_q     <= code_d;
            xpos_q     <= xpos_d;
            pal_q      <= pal_d;
            dr_start_q <= dr_start_d;
            dr_code_q  <= dr_code_d;
            dr_xpos_q  <= dr_xpos_d;
            dr_ysub_q  <= dr_ysub_d;
            dr_hflip_q <= dr_hflip_d;
            dr_vflip_q <= dr_vflip_d;
            dr_pal_q   <= dr_pal_d;
        end
    end

    assign tab_addr = tab_addr_q;
    assign dr_start = dr_start_q;
    assign dr_code  = dr_code_q;
    assign dr_xpos  = dr_xpos_q;
    assign dr_ysub  = dr_ysub_q;
    assign dr_hflip = dr_hflip_q;
    assign dr_vflip = dr_vflip_q;
    assign dr_pal   = dr_pal_q;

endmodule
